viterbi_frame_seq: RTL and testbench
====================================

# viterbi_frame_seq

Frame sequencer for the Viterbi encoder/decoder link. On a start pulse it:
- feeds a seeded LFSR bit stream plus zero tail bits into the encoder;
- forwards encoder symbols to the decoder, injecting scheduled bit errors;
- compares decoded bits against the transmitted bits;
- reports injection and residual-error counts.

It sits between the test/host logic and the `encoder2`/`decoder` pair, replacing free-running enables and hard-wired error injection.

## Interface
- FRAME_LEN, 256: payload bits per frame, must be ≥1.
- TAIL, 2: zero flush bits appended after payload; these are compared too.
- DEC_LAT, 16: cycles from `dec_en_o` high with a symbol to that symbol's decoded bit on `dec_d_i`.
- EXP_DEPTH, 64: expected-bit FIFO depth, power of two, must be ≥ DEC_LAT+8.
- PER_W, 4: width of the error period.

Ports:
- clk  in  1  clock; reset rst, asynchronous, active-low.
- rst  in  1  asynchronous active-low reset.
- start_i  in  1  begin a frame; sampled only in IDLE.
- seed_i  in  16  LFSR seed, latched at start; 0 is replaced by 16'h0001.
- err_en_i  in  1  error-injection enable, latched at start.
- err_period_i  in  PER_W  inject on every (err_period_i+1)th symbol, latched at start.
- err_mask_i  in  2  XOR mask applied to an injected symbol, latched at start.
- enc_en_o  out  1  encoder enable.
- enc_d_o  out  1  encoder data bit.
- enc_valid_i  in  1  encoder symbol valid.
- enc_sym_i  in  2  encoder symbol.
- dec_en_o  out  1  decoder enable (registered).
- dec_sym_o  out  2  decoder input symbol (registered, possibly corrupted).
- dec_d_i  in  1  decoder output bit.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle end-of-frame pulse.
- timeout_o  out  1  last frame ended by watchdog; cleared at next start.
- inj_cnt_o  out  16  symbols corrupted this frame.
- bit_err_o  out  16  decoded-bit mismatches this frame.

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE, start_i=1:
  - latch config; load LFSR;
  - clear counters, timeout_o and FIFO;
  - go to FEED.
- start_i outside IDLE is ignored.
- FEED, per cycle:
  - enc_en_o=1;
  - enc_d_o = LFSR[0] for the first FRAME_LEN bits, then 0 for TAIL bits;
  - the same bit is pushed into the expected FIFO;
  - LFSR advances during payload bits only, polynomial x^16+x^14+x^13+x^11+1, Fibonacci, shift right.
- After FRAME_LEN+TAIL bits, go to DRAIN; enc_en_o=0.
- Symbol path, every cycle regardless of state:
  - dec_en_o <= enc_valid_i;
  - dec_sym_o <= enc_sym_i ^ (inject ? mask : 0).
- Injection schedule:
  - period counter advances on each enc_valid_i;
  - inject = err_en && counter==period; the counter then resets to 0;
  - inj_cnt_o increments per injected symbol.
- Compare:
  - dec_en_o is delayed by a DEC_LAT-stage shift register to form the compare strobe;
  - on strobe, pop the FIFO; bit_err_o increments if popped bit != dec_d_i;
  - the compared count increments.
- DRAIN exits to DONE when compared count == FRAME_LEN+TAIL.
- Watchdog: a DRAIN cycle counter reaching 4*DEC_LAT+64 sets timeout_o and goes to DONE.
- DONE: done_o=1 for one cycle, then IDLE. Counters and timeout_o hold until the next start.
- Counters saturate at 16'hFFFF.
- FIFO behaviour:
  - push on full is dropped, and sets timeout_o at DONE;
  - pop on empty compares against 0.

## Timing
- Reset: state IDLE; every output 0; FIFO, LFSR, counters and shift register cleared.
- Reset mid-frame aborts immediately with no done_o.
- Start accepted at edge t:
  - busy_o=1 and enc_en_o=1 from t+1;
  - busy_o stays high through the DONE cycle.
- enc_en_o is high for exactly FRAME_LEN+TAIL consecutive cycles.
- dec_en_o/dec_sym_o lag enc_valid_i/enc_sym_i by 1 cycle.
- Compare of a symbol occurs DEC_LAT cycles after its dec_en_o cycle.
- A push and a pop in the same cycle are both performed; occupancy is unchanged.
- Period 0 means every symbol is injected.

## Test plan
- Normal frame:
  - stimulus: err_en=0, seed 16'hACE1, real encoder/decoder;
  - response: done_o once; bit_err_o=0, inj_cnt_o=0, timeout_o=0; enc_en_o high exactly 258 cycles.
- Periodic injection:
  - stimulus: err_en=1, period 7, mask 2'b10;
  - response: inj_cnt_o=32 (258 symbols); injections on symbols 8,16,…; bit_err_o=0 with real decoder.
- Residual-error counting:
  - stimulus: stub decoder driving the inverted expected bit with DEC_LAT alignment;
  - response: bit_err_o=258. A stub driving the correct bit gives 0.
- Watchdog:
  - stimulus: enc_valid_i tied 0;
  - response: DRAIN lasts 128 cycles (DEC_LAT=16); timeout_o=1, done_o pulse, compared count 0.
- Control corner cases:
  - seed 0 produces a stream identical to seed 1;
  - start_i pulsed during FEED is ignored;
  - rst deasserted→asserted mid-FEED returns all outputs to 0; a following start runs a clean frame.

Source files
------------

// File: rtl/viterbi_frame_seq.sv
// Frame sequencer for the Viterbi encoder/decoder link: drives a seeded LFSR frame into the
// encoder, forwards symbols with scheduled corruption and scores the decoded bits.
module viterbi_frame_seq #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned TAIL      = 2,
    parameter int unsigned DEC_LAT   = 16,
    parameter int unsigned EXP_DEPTH = 64,
    parameter int unsigned PER_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [15:0]      seed_i,
    input  logic             err_en_i,
    input  logic [PER_W-1:0] err_period_i,
    input  logic [1:0]       err_mask_i,
    output logic             enc_en_o,
    output logic             enc_d_o,
    input  logic             enc_valid_i,
    input  logic [1:0]       enc_sym_i,
    output logic             dec_en_o,
    output logic [1:0]       dec_sym_o,
    input  logic             dec_d_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [15:0]      inj_cnt_o,
    output logic [15:0]      bit_err_o
);

    localparam int unsigned WD_LIM = 4 * DEC_LAT + 64;
    localparam int unsigned AW     = $clog2(EXP_DEPTH);
    localparam int unsigned WW     = $clog2(WD_LIM);

    localparam logic [15:0]   LEN16   = 16'(FRAME_LEN);
    localparam logic [15:0]   TOT16   = 16'(FRAME_LEN + TAIL);
    localparam logic [15:0]   LAST16  = 16'(FRAME_LEN + TAIL - 1);
    localparam logic [WW-1:0] WD_LAST = WW'(WD_LIM - 1);

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [15:0]          feed_cnt_q, feed_cnt_d;
    logic [WW-1:0]        wd_cnt_q, wd_cnt_d;
    logic                 err_en_q, err_en_d;
    logic [PER_W-1:0]     period_q, period_d;
    logic [1:0]           mask_q, mask_d;
    logic [PER_W-1:0]     per_cnt_q, per_cnt_d;
    logic                 dec_en_q, dec_en_d;
    logic [1:0]           dec_sym_q, dec_sym_d;
    logic [DEC_LAT-1:0]   sr_q, sr_d;
    logic [EXP_DEPTH-1:0] fifo_q, fifo_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic                 ovf_q, ovf_d;
    logic [15:0]          cmp_cnt_q, cmp_cnt_d;
    logic [15:0]          inj_cnt_q, inj_cnt_d;
    logic [15:0]          bit_err_q, bit_err_d;
    logic                 timeout_q, timeout_d;

    logic full, empty, strobe, pop_bit, payload, feed_bit, lfsr_fb, inject, push;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign strobe   = sr_q[DEC_LAT-1];
    assign pop_bit  = empty ? 1'b0 : fifo_q[rd_ptr_q[AW-1:0]];
    assign payload  = (feed_cnt_q < LEN16);
    assign feed_bit = payload ? lfsr_q[0] : 1'b0;
    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in a right-shifting register
    assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign inject   = enc_valid_i && err_en_q && (per_cnt_q == period_q);
    assign push     = (state_q == StFeed);

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        feed_cnt_d = feed_cnt_q;
        wd_cnt_d   = wd_cnt_q;
        err_en_d   = err_en_q;
        period_d   = period_q;
        mask_d     = mask_q;
        per_cnt_d  = per_cnt_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_d      = ovf_q;
        cmp_cnt_d  = cmp_cnt_q;
        inj_cnt_d  = inj_cnt_q;
        bit_err_d  = bit_err_q;
        timeout_d  = timeout_q;
        enc_en_o   = 1'b0;
        enc_d_o    = 1'b0;
        done_o     = 1'b0;

        // Symbol path runs every cycle, independent of the frame state
        dec_en_d  = enc_valid_i;
        dec_sym_d = enc_sym_i ^ (inject ? mask_q : 2'b00);
        sr_d      = (sr_q << 1) | DEC_LAT'(dec_en_q);

        if (enc_valid_i) begin
            per_cnt_d = (per_cnt_q == period_q) ? '0 : per_cnt_q + 1'b1;
        end
        if (inject) begin
            inj_cnt_d = sat_inc(inj_cnt_q);
        end

        if (push) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                fifo_d[wr_ptr_q[AW-1:0]] = feed_bit;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
        if (strobe) begin
            if (!empty) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (pop_bit != dec_d_i) begin
                bit_err_d = sat_inc(bit_err_q);
            end
            cmp_cnt_d = sat_inc(cmp_cnt_q);
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    err_en_d   = err_en_i;
                    period_d   = err_period_i;
                    mask_d     = err_mask_i;
                    lfsr_d     = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
                    feed_cnt_d = '0;
                    wd_cnt_d   = '0;
                    per_cnt_d  = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    ovf_d      = 1'b0;
                    cmp_cnt_d  = '0;
                    inj_cnt_d  = '0;
                    bit_err_d  = '0;
                    timeout_d  = 1'b0;
                    state_d    = StFeed;
                end
            end
            StFeed: begin
                enc_en_o   = 1'b1;
                enc_d_o    = feed_bit;
                feed_cnt_d = feed_cnt_q + 16'd1;
                if (payload) begin
                    lfsr_d = {lfsr_fb, lfsr_q[15:1]};
                end
                if (feed_cnt_q == LAST16) begin
                    wd_cnt_d = '0;
                    state_d  = StDrain;
                end
            end
            StDrain: begin
                if (cmp_cnt_q == TOT16) begin
                    timeout_d = timeout_q | ovf_q;
                    state_d   = StDone;
                end else if (wd_cnt_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            lfsr_q     <= '0;
            feed_cnt_q <= '0;
            wd_cnt_q   <= '0;
            err_en_q   <= 1'b0;
            period_q   <= '0;
            mask_q     <= '0;
            per_cnt_q  <= '0;
            dec_en_q   <= 1'b0;
            dec_sym_q  <= '0;
            sr_q       <= '0;
            fifo_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            cmp_cnt_q  <= '0;
            inj_cnt_q  <= '0;
            bit_err_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            feed_cnt_q <= feed_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            err_en_q   <= err_en_d;
            period_q   <= period_d;
            mask_q     <= mask_d;
            per_cnt_q  <= per_cnt_d;
            dec_en_q   <= dec_en_d;
            dec_sym_q  <= dec_sym_d;
            sr_q       <= sr_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            cmp_cnt_q  <= cmp_cnt_d;
            inj_cnt_q  <= inj_cnt_d;
            bit_err_q  <= bit_err_d;
            timeout_q  <= timeout_d;
        end
    end

    assign dec_en_o  = dec_en_q;
    assign dec_sym_o = dec_sym_q;
    assign busy_o    = (state_q != StIdle);
    assign timeout_o = timeout_q;
    assign inj_cnt_o = inj_cnt_q;
    assign bit_err_o = bit_err_q;

endmodule

// File: tb/tb_viterbi_frame_seq.sv
// Directed bench for viterbi_frame_seq with stub encoder (sym = {d,d}) and a stub decoder
// that returns sym[0] (optionally inverted) DEC_LAT cycles after dec_en_o.
module tb_viterbi_frame_seq;

    localparam int FRAME_LEN = 256;
    localparam int TAIL      = 2;
    localparam int DEC_LAT   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] seed_i = 16'h0;
    logic        err_en_i = 1'b0;
    logic [3:0]  err_period_i = 4'd0;
    logic [1:0]  err_mask_i = 2'b00;
    logic        enc_en_o, enc_d_o, dec_en_o, dec_d_i, busy_o, done_o, timeout_o;
    logic        enc_valid_i;
    logic [1:0]  enc_sym_i, dec_sym_o;
    logic [15:0] inj_cnt_o, bit_err_o;

    logic        inv = 1'b0;
    logic        vld_off = 1'b0;
    logic        mon_clr = 1'b0;
    logic [15:0] m_seed = 16'h1;
    logic [DEC_LAT-1:0] pipe;

    int checks = 0;
    int errors = 0;
    int en_cycles, drain_cycles, done_cnt, stream_err, sym_err, feed_idx, sym_idx;
    logic [15:0] m_lfsr;
    logic        done_seen;

    viterbi_frame_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .seed_i      (seed_i),
        .err_en_i    (err_en_i),
        .err_period_i(err_period_i),
        .err_mask_i  (err_mask_i),
        .enc_en_o    (enc_en_o),
        .enc_d_o     (enc_d_o),
        .enc_valid_i (enc_valid_i),
        .enc_sym_i   (enc_sym_i),
        .dec_en_o    (dec_en_o),
        .dec_sym_o   (dec_sym_o),
        .dec_d_i     (dec_d_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
        .inj_cnt_o   (inj_cnt_o),
        .bit_err_o   (bit_err_o)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_valid_i <= 1'b0;
            enc_sym_i   <= 2'b00;
            pipe        <= '0;
        end else begin
            enc_valid_i <= enc_en_o & ~vld_off;
            enc_sym_i   <= {enc_d_o, enc_d_o};
            pipe        <= {pipe[DEC_LAT-2:0], dec_sym_o[0] ^ inv};
        end
    end
    assign dec_d_i = pipe[DEC_LAT-1];

    // Reference LFSR stream, frame timing and injection schedule
    always @(negedge clk) begin
        if (mon_clr) begin
            en_cycles = 0; drain_cycles = 0; done_cnt = 0; stream_err = 0; sym_err = 0;
            feed_idx = 0; sym_idx = 0; m_lfsr = m_seed;
        end else begin
            if (enc_en_o) begin
                if (enc_d_o !== ((feed_idx < FRAME_LEN) ? m_lfsr[0] : 1'b0)) stream_err++;
                if (feed_idx < FRAME_LEN)
                    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
                feed_idx++;
                en_cycles++;
            end
            if (busy_o && !enc_en_o && !done_o) drain_cycles++;
            if (done_o) done_cnt++;
            if (dec_en_o) begin
                if ((dec_sym_o[1] ^ dec_sym_o[0]) !==
                    (err_en_i && (sym_idx % (int'(err_period_i) + 1) == int'(err_period_i))))
                    sym_err++;
                sym_idx++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_frame(input logic [15:0] seed, input logic [15:0] mseed, input logic een,
                             input logic [3:0] per, input logic inv_i, input logic voff,
                             input logic mid_start);
        @(negedge clk);
        seed_i = seed; m_seed = mseed; err_en_i = een; err_period_i = per;
        err_mask_i = 2'b10; inv = inv_i; vld_off = voff;
        @(posedge clk); mon_clr = 1'b1;
        @(posedge clk); mon_clr = 1'b0;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        if (mid_start) begin
            repeat (40) @(negedge clk);
            start_i = 1'b1;
            @(negedge clk); start_i = 1'b0;
        end
        done_seen = 1'b0;
        for (int i = 0; i < 3000 && !done_seen; i++) begin
            @(negedge clk);
            if (done_o) done_seen = 1'b1;
        end
        chk("done_seen", 32'(done_seen), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_enc_en", 32'(enc_en_o), 0);
        chk("rst_dec_en", 32'(dec_en_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_inj", 32'(inj_cnt_o), 0);
        chk("rst_bit_err", 32'(bit_err_o), 0);
        chk("rst_timeout", 32'(timeout_o), 0);
        rst = 1'b1;

        // Normal frame
        run_frame(16'hACE1, 16'hACE1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("norm_en_cycles", 32'(en_cycles), 258);
        chk("norm_done_cnt", 32'(done_cnt), 1);
        chk("norm_stream", 32'(stream_err), 0);
        chk("norm_bit_err", 32'(bit_err_o), 0);
        chk("norm_inj", 32'(inj_cnt_o), 0);
        chk("norm_timeout", 32'(timeout_o), 0);
        chk("norm_busy_after", 32'(busy_o), 0);

        // Periodic injection, period 7, mask 2'b10
        run_frame(16'h1234, 16'h1234, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        chk("inj_cnt", 32'(inj_cnt_o), 32);
        chk("inj_schedule", 32'(sym_err), 0);
        chk("inj_bit_err", 32'(bit_err_o), 0);

        // Stub decoder returns the inverted bit
        run_frame(16'hBEEF, 16'hBEEF, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("inv_bit_err", 32'(bit_err_o), 258);

        // Reset mid-FEED with injection active
        @(negedge clk);
        err_en_i = 1'b1; err_period_i = 4'd0; inv = 1'b0; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 0);
        chk("mid_rst_enc_en", 32'(enc_en_o), 0);
        chk("mid_rst_dec_sym", 32'({dec_en_o, dec_sym_o}), 0);
        chk("mid_rst_inj", 32'(inj_cnt_o), 0);
        chk("mid_rst_bit_err", 32'(bit_err_o), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_frame(16'h5A5A, 16'h5A5A, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_en_cycles", 32'(en_cycles), 258);
        chk("post_rst_stream", 32'(stream_err), 0);
        chk("post_rst_bit_err", 32'(bit_err_o), 0);

        // Watchdog: encoder never produces a valid symbol
        run_frame(16'hACE1, 16'hACE1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("wd_timeout", 32'(timeout_o), 1);
        chk("wd_drain_cycles", 32'(drain_cycles), 128);
        chk("wd_done_cnt", 32'(done_cnt), 1);
        chk("wd_bit_err", 32'(bit_err_o), 0);

        // Seed 0 must match the seed-1 stream; timeout clears on start
        run_frame(16'h0000, 16'h0001, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("seed0_stream", 32'(stream_err), 0);
        chk("seed0_timeout", 32'(timeout_o), 0);

        // Start pulsed during FEED is ignored; period 0 hits every symbol
        run_frame(16'hC0DE, 16'hC0DE, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("mid_start_en_cycles", 32'(en_cycles), 258);
        chk("mid_start_done_cnt", 32'(done_cnt), 1);
        chk("per0_inj", 32'(inj_cnt_o), 258);
        chk("per0_schedule", 32'(sym_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
